puf_majority_sampler: RTL and testbench
=======================================

// Module: puf_majority_sampler
// PURPOSE
//   Parametrised PUF readout engine and successor to the single-pass PUF byte reader in secure_key_system.
//   - Drives the clocked PUF read protocol (puf_clk/puf_enable/puf_addr/puf_data).
//   - Reads every PUF byte NUM_READS times and produces a per-bit majority-voted response.
//   - Sits between the PUF macro and the fuzzy extractor; its response feeds key generation.
// PARAMETERS
//   PUF_BYTES  8   bytes per pass; response width = PUF_BYTES*8
//   NUM_READS  3   passes over the array; odd, >=1 (elaboration $error otherwise)
//   CLK_DIV    2   clk cycles per puf_clk phase (low and high); >=1
// PORTS
//   clk            in   1                   system clock, all logic on posedge
//   reset_n        in   1                   synchronous, active-low reset
//   start          in   1                   begin readout; sampled only in IDLE
//   busy           out  1                   high from cycle after start until done
//   done           out  1                   one-cycle pulse, response ready
//   resp           out  PUF_BYTES*8         voted response; byte k at [8k+7:8k]
//   resp_valid     out  1                   level; set with done, cleared on next accepted start
//   puf_clk        out  1                   generated PUF read clock, low when idle
//   puf_enable     out  1                   high for the whole readout
//   puf_addr       out  $clog2(PUF_BYTES)   current byte address (min width 1)
//   puf_data       in   8                   PUF byte, valid after puf_clk rising edge
//   unstable_mask  out  PUF_BYTES*8         [STABILITY_MASK_EN only] bit disagreed across passes
//   unstable_count out  $clog2(PUF_BYTES*8+1) [STABILITY_MASK_EN only] popcount of mask
// BEHAVIOUR
//   Reset: every output 0, including resp, masks and counters. Reset mid-readout aborts; no done pulse.
//   FSM states:
//     IDLE    start=1 -> SETUP, clear per-bit counters and resp_valid.
//     SETUP   CLK_DIV cycles; puf_clk=0, puf_addr/puf_enable driven.
//     HIGH    CLK_DIV cycles; puf_clk=1.
//     CAPTURE 1 cycle; register puf_data, add each bit to its ones-counter.
//             If more bytes remain -> SETUP with the next addr. After the last byte of the last pass -> VOTE.
//     VOTE    resp[i] = (ones[i] > NUM_READS/2); mask[i] = ones[i] != 0 && ones[i] != NUM_READS.
//     DONE    done=1, resp_valid=1 -> IDLE.
//   Order: outer loop pass 0..NUM_READS-1, inner loop addr 0..PUF_BYTES-1.
//     addr wraps to 0 at each new pass.
//   Latency: done is high exactly NUM_READS*PUF_BYTES*(2*CLK_DIV+1)+2 cycles after the edge that samples start.
//   Ones-counters are $clog2(NUM_READS+1) bits wide; they cannot overflow.
//     NUM_READS=1 degenerates to plain copy, mask always 0.
//   start while busy is ignored with no effect. start in the DONE cycle is ignored.
//   puf_enable drops in the DONE cycle. puf_addr holds its last value, puf_clk is 0.
//   resp holds its value until the next VOTE; resp_valid drops on accepted start.
// CONFIGURATION
//   STABILITY_MASK_EN defined:
//     unstable_mask/unstable_count ports exist; updated in VOTE; reset to 0.
//     Both are cleared on accepted start.
//   STABILITY_MASK_EN undefined:
//     ports and mask/popcount logic are absent; behaviour is otherwise identical.
// STRUCTURE
//   Package puf_sampler_pkg:
//     - state enum (IDLE, SETUP, HIGH, CAPTURE, VOTE, DONE)
//     - function cnt_w(n) = $clog2(n+1)
//   Sub-module puf_bit_voter: one ones-counter, clear/inc/vote/unstable for one bit.
//     Generated PUF_BYTES*8 times.
// TESTING (PUF_BYTES=8, NUM_READS=3, CLK_DIV=1 unless noted)
//   1. Stable PUF, mem = 8'h11..8'h88, start pulse
//      -> resp = 64'h8877665544332211, done at cycle 74, mask = 0.
//   2. Byte 2 bit 0 inverted on pass 1 only -> resp unchanged from test 1,
//      unstable_mask = 64'h0000_0000_0001_0000, unstable_count = 1.
//   3. Byte 5 reads 8'hFF, 8'h00, 8'hFF over the passes -> resp byte 5 = 8'hFF, mask byte 5 = 8'hFF, count = 8.
//   4. Second start at cycle 10 while busy
//      -> ignored; exactly one done at cycle 74; puf_addr sequence 0..7 repeated three times.
//   5. reset_n low at cycle 30 -> all outputs 0 next cycle, no done.
//      A fresh start afterwards completes normally at 74 cycles.
//   6. NUM_READS=1, CLK_DIV=2 -> resp equals the raw memory, done at cycle 42, mask = 0.

Source files
------------

// File: rtl/puf_majority_sampler_pkg.sv
// Shared types and helpers for the PUF majority sampler.
package puf_sampler_pkg;

  // Readout sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StCapture,
    StVote,
    StDone
  } state_e;

  // Bits needed to hold a count of 0..n
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/puf_majority_sampler_if.sv
// Clocked PUF read bus: the sampler is the master, the PUF macro the slave.
interface puf_majority_sampler_if #(
  parameter int unsigned AddrW = 3
);
  logic             puf_clk;
  logic             puf_enable;
  logic [AddrW-1:0] puf_addr;
  logic [7:0]       puf_data;

  modport master (
    output puf_clk,
    output puf_enable,
    output puf_addr,
    input  puf_data
  );

  modport slave (
    input  puf_clk,
    input  puf_enable,
    input  puf_addr,
    output puf_data
  );
endinterface

// File: rtl/puf_majority_sampler_bit_voter.sv
// One response bit: counts ones across passes and votes on the result.
// Optional build macro: STABILITY_MASK_EN adds the disagreement flag.
module puf_bit_voter
  import puf_sampler_pkg::*;
#(
  parameter int unsigned NUM_READS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  input  logic data,
  output logic vote
`ifdef STABILITY_MASK_EN
  ,
  output logic unstable
`endif
);

  localparam int unsigned CntW = cnt_w(NUM_READS);

  logic [CntW-1:0] ones_q;

  // Ones-counter: cleared on accepted start, bumped when this bit's byte is captured as 1
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ones_q <= '0;
    end else if (clr) begin
      ones_q <= '0;
    end else if (inc && data) begin
      ones_q <= ones_q + CntW'(1);
    end
  end

  assign vote = (ones_q > CntW'(NUM_READS / 2));

`ifdef STABILITY_MASK_EN
  assign unstable = (ones_q != '0) && (ones_q != CntW'(NUM_READS));
`endif

endmodule

// File: rtl/puf_majority_sampler.sv
// PUF readout engine: reads the array NUM_READS times and majority-votes each bit.
// Optional build macro: STABILITY_MASK_EN adds unstable_mask / unstable_count.
module puf_majority_sampler
  import puf_sampler_pkg::*;
#(
  parameter int unsigned PUF_BYTES = 8,
  parameter int unsigned NUM_READS = 3,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [PUF_BYTES*8-1:0]       resp,
  output logic                         resp_valid,
`ifdef STABILITY_MASK_EN
  output logic [PUF_BYTES*8-1:0]       unstable_mask,
  output logic [cnt_w(PUF_BYTES*8)-1:0] unstable_count,
`endif
  puf_majority_sampler_if.master       puf
);

  localparam int unsigned RespW = PUF_BYTES * 8;
  localparam int unsigned AddrW = (PUF_BYTES > 1) ? $clog2(PUF_BYTES) : 1;
  localparam int unsigned PassW = cnt_w(NUM_READS);
  localparam int unsigned DivW  = cnt_w(CLK_DIV);

  if ((NUM_READS < 1) || ((NUM_READS % 2) == 0)) begin : g_bad_reads
    $error("NUM_READS must be odd and >= 1");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be >= 1");
  end

  state_e             state_q;
  logic [DivW-1:0]    div_q;
  logic [PassW-1:0]   pass_q;
  logic [AddrW-1:0]   addr_q;
  logic               puf_clk_q;
  logic               puf_en_q;
  logic               accept;
  logic               last_addr;
  logic               last_div;
  logic [RespW-1:0]   vote_vec;

  // Start is ignored while busy and during the done pulse
  assign accept    = (state_q == StIdle) && start && !done;
  assign last_addr = (addr_q == AddrW'(PUF_BYTES - 1));
  assign last_div  = (div_q == DivW'(CLK_DIV - 1));

  assign puf.puf_clk    = puf_clk_q;
  assign puf.puf_enable = puf_en_q;
  assign puf.puf_addr   = addr_q;

`ifdef STABILITY_MASK_EN
  logic [RespW-1:0]              unstable_vec;
  logic [cnt_w(RespW)-1:0]       pop_cnt;

  // Popcount of the per-bit disagreement flags
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < RespW; i++) begin
      pop_cnt = pop_cnt + cnt_w(RespW)'(unstable_vec[i]);
    end
  end
`endif

  for (genvar i = 0; i < RespW; i++) begin : g_voter
    puf_bit_voter #(
      .NUM_READS (NUM_READS)
    ) u_voter (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (accept),
      .inc      ((state_q == StCapture) && (addr_q == AddrW'(i / 8))),
      .data     (puf.puf_data[i % 8]),
      .vote     (vote_vec[i])
`ifdef STABILITY_MASK_EN
      ,
      .unstable (unstable_vec[i])
`endif
    );
  end

  // Readout sequencer with registered outputs; done/resp_valid land one edge after DONE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      pass_q     <= '0;
      addr_q     <= '0;
      puf_clk_q  <= 1'b0;
      puf_en_q   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      resp       <= '0;
      resp_valid <= 1'b0;
`ifdef STABILITY_MASK_EN
      unstable_mask  <= '0;
      unstable_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StSetup;
            div_q      <= '0;
            pass_q     <= '0;
            addr_q     <= '0;
            puf_en_q   <= 1'b1;
            busy       <= 1'b1;
            resp_valid <= 1'b0;
`ifdef STABILITY_MASK_EN
            unstable_mask  <= '0;
            unstable_count <= '0;
`endif
          end
        end
        StSetup: begin
          if (last_div) begin
            div_q     <= '0;
            puf_clk_q <= 1'b1;
            state_q   <= StHigh;
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        StHigh: begin
          if (last_div) begin
            div_q     <= '0;
            puf_clk_q <= 1'b0;
            state_q   <= StCapture;
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        StCapture: begin
          // Voters sample puf_data on this edge
          if (!last_addr) begin
            addr_q  <= addr_q + AddrW'(1);
            state_q <= StSetup;
          end else if (pass_q != PassW'(NUM_READS - 1)) begin
            addr_q  <= '0;
            pass_q  <= pass_q + PassW'(1);
            state_q <= StSetup;
          end else begin
            state_q <= StVote;
          end
        end
        StVote: begin
          resp    <= vote_vec;
`ifdef STABILITY_MASK_EN
          unstable_mask  <= unstable_vec;
          unstable_count <= pop_cnt;
`endif
          state_q <= StDone;
        end
        StDone: begin
          done       <= 1'b1;
          resp_valid <= 1'b1;
          busy       <= 1'b0;
          puf_en_q   <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_majority_sampler.sv
// Directed bench for puf_majority_sampler: two instances (3 reads / div 1, 1 read / div 2).
// Mask checks are compiled in when STABILITY_MASK_EN is defined.
module tb_puf_majority_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- instance A: 8 bytes, 3 reads, CLK_DIV 1 ----------------
  logic        reset_n_a = 1'b0;
  logic        start_a   = 1'b0;
  logic        busy_a, done_a, resp_valid_a;
  logic [63:0] resp_a;
  logic [63:0] mask_a;
  logic [6:0]  cnt_a;

  puf_majority_sampler_if #(.AddrW(3)) pif_a ();

  puf_majority_sampler #(
    .PUF_BYTES (8),
    .NUM_READS (3),
    .CLK_DIV   (1)
  ) u_dut_a (
    .clk            (clk),
    .reset_n        (reset_n_a),
    .start          (start_a),
    .busy           (busy_a),
    .done           (done_a),
    .resp           (resp_a),
    .resp_valid     (resp_valid_a),
`ifdef STABILITY_MASK_EN
    .unstable_mask  (mask_a),
    .unstable_count (cnt_a),
`endif
    .puf            (pif_a.master)
  );

`ifndef STABILITY_MASK_EN
  assign mask_a = '0;
  assign cnt_a  = '0;
`endif

  // ---------------- instance B: 8 bytes, 1 read, CLK_DIV 2 ----------------
  logic        reset_n_b = 1'b0;
  logic        start_b   = 1'b0;
  logic        busy_b, done_b, resp_valid_b;
  logic [63:0] resp_b;
  logic [63:0] mask_b;
  logic [6:0]  cnt_b;

  puf_majority_sampler_if #(.AddrW(3)) pif_b ();

  puf_majority_sampler #(
    .PUF_BYTES (8),
    .NUM_READS (1),
    .CLK_DIV   (2)
  ) u_dut_b (
    .clk            (clk),
    .reset_n        (reset_n_b),
    .start          (start_b),
    .busy           (busy_b),
    .done           (done_b),
    .resp           (resp_b),
    .resp_valid     (resp_valid_b),
`ifdef STABILITY_MASK_EN
    .unstable_mask  (mask_b),
    .unstable_count (cnt_b),
`endif
    .puf            (pif_b.master)
  );

`ifndef STABILITY_MASK_EN
  assign mask_b = '0;
  assign cnt_b  = '0;
`endif

  // ---------------- PUF models ----------------
  // pat_x[pass][byte]; the model picks the pass from the number of puf_clk rises seen
  logic [7:0] pat_a [0:2][0:7];
  logic [7:0] pat_b [0:7];
  int rd_a = 0, base_a = 0, addr_err_a = 0;
  int rd_b = 0, base_b = 0, addr_err_b = 0;
  logic pclk_a_prev = 1'b0, pclk_b_prev = 1'b0;

  always @(negedge clk) begin
    int idx;
    if (pif_a.puf_clk && !pclk_a_prev) begin
      idx = rd_a - base_a;
      if (int'(pif_a.puf_addr) != (idx % 8)) addr_err_a++;
      pif_a.puf_data = ((idx / 8) < 3) ? pat_a[idx / 8][pif_a.puf_addr] : 8'h00;
      rd_a++;
    end
    pclk_a_prev = pif_a.puf_clk;
  end

  always @(negedge clk) begin
    int idx;
    if (pif_b.puf_clk && !pclk_b_prev) begin
      idx = rd_b - base_b;
      if (int'(pif_b.puf_addr) != (idx % 8)) addr_err_b++;
      pif_b.puf_data = pat_b[pif_b.puf_addr];
      rd_b++;
    end
    pclk_b_prev = pif_b.puf_clk;
  end

  task automatic set_stable_a();
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 8; k++) pat_a[p][k] = 8'((k + 1) * 8'h11);
  endtask

  // Pulse start on A, then watch 110 cycles; cycle c is the c-th edge after the one sampling start
  task automatic run_a(input int second_at, output int lat, output int ndone, output int nreads,
                       output int nerr, output logic rv1, output logic busy1);
    int err0;
    base_a = rd_a;
    err0   = addr_err_a;
    lat    = -1;
    ndone  = 0;
    rv1    = 1'bx;
    busy1  = 1'bx;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      start_a = (c == second_at);
      @(posedge clk); #1;
      start_a = 1'b0;
      if (c == 1) begin
        rv1   = resp_valid_a;
        busy1 = busy_a;
      end
      if (done_a) begin
        ndone++;
        if (lat < 0) lat = c;
      end
    end
    nreads = rd_a - base_a;
    nerr   = addr_err_a - err0;
  endtask

  int   lat, ndone, nreads, nerr;
  logic rv1, busy1;
  logic [63:0] raw_b;

  initial begin
    pif_a.puf_data = 8'h00;
    pif_b.puf_data = 8'h00;
    set_stable_a();
    raw_b = 64'h0123_4567_89AB_CDEF;
    for (int k = 0; k < 8; k++) pat_b[k] = raw_b[8*k +: 8];

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl_a", {59'd0, busy_a, done_a, resp_valid_a, pif_a.puf_enable, pif_a.puf_clk},
          64'd0);
    check("reset_resp_a", resp_a, 64'd0);
    check("reset_addr_a", {61'd0, pif_a.puf_addr}, 64'd0);
    check("reset_mask_a", mask_a, 64'd0);
    check("reset_ctrl_b", {60'd0, busy_b, done_b, resp_valid_b, pif_b.puf_enable}, 64'd0);
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;
    @(posedge clk); #1;

    // 1: stable array
    run_a(0, lat, ndone, nreads, nerr, rv1, busy1);
    check("t1_latency", 64'(lat), 64'd74);
    check("t1_done_pulses", 64'(ndone), 64'd1);
    check("t1_resp", resp_a, 64'h8877_6655_4433_2211);
    check("t1_resp_valid", {63'd0, resp_valid_a}, 64'd1);
    check("t1_reads", 64'(nreads), 64'd24);
    check("t1_addr_order", 64'(nerr), 64'd0);
    check("t1_idle_bus", {61'd0, busy_a, pif_a.puf_enable, pif_a.puf_clk}, 64'd0);
    check("t1_addr_hold", {61'd0, pif_a.puf_addr}, 64'd7);
`ifdef STABILITY_MASK_EN
    check("t1_mask", mask_a, 64'd0);
    check("t1_count", {57'd0, cnt_a}, 64'd0);
`endif

    // 2: byte 2 bit 0 flips on pass 1
    set_stable_a();
    pat_a[1][2] = 8'h32;
    run_a(0, lat, ndone, nreads, nerr, rv1, busy1);
    check("t2_rv_cleared", {63'd0, rv1}, 64'd0);
    check("t2_busy", {63'd0, busy1}, 64'd1);
    check("t2_latency", 64'(lat), 64'd74);
    check("t2_resp", resp_a, 64'h8877_6655_4433_2211);
`ifdef STABILITY_MASK_EN
    check("t2_mask", mask_a, 64'h0000_0000_0001_0000);
    check("t2_count", {57'd0, cnt_a}, 64'd1);
`endif

    // 3: byte 5 reads FF, 00, FF
    set_stable_a();
    pat_a[0][5] = 8'hFF;
    pat_a[1][5] = 8'h00;
    pat_a[2][5] = 8'hFF;
    run_a(0, lat, ndone, nreads, nerr, rv1, busy1);
    check("t3_resp", resp_a, 64'h8877_FF55_4433_2211);
`ifdef STABILITY_MASK_EN
    check("t3_mask", mask_a, 64'h0000_FF00_0000_0000);
    check("t3_count", {57'd0, cnt_a}, 64'd8);
`endif

    // 4: second start while busy is ignored
    set_stable_a();
    run_a(10, lat, ndone, nreads, nerr, rv1, busy1);
    check("t4_latency", 64'(lat), 64'd74);
    check("t4_done_pulses", 64'(ndone), 64'd1);
    check("t4_reads", 64'(nreads), 64'd24);
    check("t4_addr_order", 64'(nerr), 64'd0);
    check("t4_resp", resp_a, 64'h8877_6655_4433_2211);

    // 5: reset at cycle 30 aborts the readout
    base_a  = rd_a;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int c = 1; c <= 29; c++) @(posedge clk);
    #1;
    reset_n_a = 1'b0;
    @(posedge clk); #1;
    check("t5_ctrl_zero", {59'd0, busy_a, done_a, resp_valid_a, pif_a.puf_enable, pif_a.puf_clk},
          64'd0);
    check("t5_resp_zero", resp_a, 64'd0);
    check("t5_addr_zero", {61'd0, pif_a.puf_addr}, 64'd0);
    ndone = 0;
    for (int c = 0; c < 90; c++) begin
      if (c == 2) reset_n_a = 1'b1;
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    check("t5_no_done", 64'(ndone), 64'd0);
    run_a(0, lat, ndone, nreads, nerr, rv1, busy1);
    check("t5_restart_latency", 64'(lat), 64'd74);
    check("t5_restart_resp", resp_a, 64'h8877_6655_4433_2211);

    // 6: single read, CLK_DIV 2 on instance B
    base_b  = rd_b;
    lat     = -1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (done_b && lat < 0) lat = c;
    end
    check("t6_latency", 64'(lat), 64'd42);
    check("t6_resp", resp_b, 64'h0123_4567_89AB_CDEF);
    check("t6_reads", 64'(rd_b - base_b), 64'd8);
    check("t6_addr_order", 64'(addr_err_b), 64'd0);
`ifdef STABILITY_MASK_EN
    check("t6_mask", mask_b, 64'd0);
    check("t6_count", {57'd0, cnt_b}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
